// File: rtl/registers_scoreboard_pkg.sv
// Shared defaults for the register file / scoreboard slice.
// Depth is always derived from the address width so the two cannot drift apart.
package registers_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

endpackage

// File: rtl/registers_scoreboard_if.sv
// Read, write-back and issue signals of the register file, bundled.
// The master drives the addresses and data; the slave returns read data and busy flags.
interface registers_scoreboard_if
  import registers_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [DATA_W-1:0] RDdata_i;
  logic              RegWrite_i;
  logic              Issue_i;
  logic [ADDR_W-1:0] IssueAddr_i;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic              RSbusy_o;
  logic              RTbusy_o;
  logic [ADDR_W:0]   PendCnt_o;

  modport master (
    output RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i, Issue_i, IssueAddr_i,
    input  RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, PendCnt_o
  );

  modport slave (
    input  RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i, Issue_i, IssueAddr_i,
    output RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, PendCnt_o
  );

endinterface

// File: rtl/registers_scoreboard_sb.sv
// Busy-bit scoreboard: one bit per register, set by issue and cleared by write-back.
// The pending count is registered from the next-state vector so it matches the bits after each edge.
module reg_scoreboard
  import registers_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  cnt_next;

  // Set is applied after clear so an issue and write-back to the same entry leaves it busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    if (ZERO_REG) busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_next;
      pend_cnt <= cnt_next;
    end
  end

  assign rs_busy = busy[rs_addr] && !(BYPASS && clr_en && (clr_addr == rs_addr));
  assign rt_busy = busy[rt_addr] && !(BYPASS && clr_en && (clr_addr == rt_addr));

endmodule

// File: rtl/registers_scoreboard.sv
// Two-read, one-write register file with optional write-back forwarding and a busy scoreboard.
// Storage and read muxing live here; busy tracking is delegated to reg_scoreboard.
module registers_scoreboard
  import registers_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  registers_scoreboard_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_allowed;
  logic              rs_fwd;
  logic              rt_fwd;

  assign wr_allowed = bus.RegWrite_i && !(ZERO_REG && (bus.RDaddr_i == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_allowed) begin
      regs[bus.RDaddr_i] <= bus.RDdata_i;
    end
  end

  assign rs_fwd = BYPASS && bus.RegWrite_i && (bus.RDaddr_i == bus.RSaddr_i);
  assign rt_fwd = BYPASS && bus.RegWrite_i && (bus.RDaddr_i == bus.RTaddr_i);

  // The hard-wired zero check comes last so it overrides forwarding of a write to r0.
  always_comb begin
    bus.RSdata_o = regs[bus.RSaddr_i];
    if (rs_fwd) bus.RSdata_o = bus.RDdata_i;
    if (ZERO_REG && (bus.RSaddr_i == '0)) bus.RSdata_o = '0;
    bus.RTdata_o = regs[bus.RTaddr_i];
    if (rt_fwd) bus.RTdata_o = bus.RDdata_i;
    if (ZERO_REG && (bus.RTaddr_i == '0)) bus.RTdata_o = '0;
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_en   (bus.Issue_i),
    .set_addr (bus.IssueAddr_i),
    .clr_en   (bus.RegWrite_i),
    .clr_addr (bus.RDaddr_i),
    .rs_addr  (bus.RSaddr_i),
    .rt_addr  (bus.RTaddr_i),
    .rs_busy  (bus.RSbusy_o),
    .rt_busy  (bus.RTbusy_o),
    .pend_cnt (bus.PendCnt_o)
  );

endmodule

// File: tb/tb_registers_scoreboard.sv
// Directed bench: drives a forwarding build (dut_a) and a non-forwarding build (dut_b)
// with identical stimulus and checks hand-computed results.
module tb_registers_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  registers_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  registers_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

  registers_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_a.slave)
  );

  registers_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(
    input logic          r,
    input logic [AW-1:0] rs,
    input logic [AW-1:0] rt,
    input logic          we,
    input logic [AW-1:0] rd,
    input logic [DW-1:0] data,
    input logic          iss,
    input logic [AW-1:0] iss_addr
  );
    rst              = r;
    if_a.RSaddr_i    = rs;  if_b.RSaddr_i    = rs;
    if_a.RTaddr_i    = rt;  if_b.RTaddr_i    = rt;
    if_a.RegWrite_i  = we;  if_b.RegWrite_i  = we;
    if_a.RDaddr_i    = rd;  if_b.RDaddr_i    = rd;
    if_a.RDdata_i    = data; if_b.RDdata_i   = data;
    if_a.Issue_i     = iss; if_b.Issue_i     = iss;
    if_a.IssueAddr_i = iss_addr; if_b.IssueAddr_i = iss_addr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    tick();

    // Post-reset reads on a spread of addresses
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("reset_pend", 32'(if_a.PendCnt_o), 32'd0);
    for (int i = 0; i < 32; i += 13) begin
      applyStimulus(1'b0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      checkOutput($sformatf("reset_rs_data_r%0d", i), if_a.RSdata_o, 32'h0);
      checkOutput($sformatf("reset_rt_data_r%0d", 31 - i), if_a.RTdata_o, 32'h0);
      checkOutput($sformatf("reset_rs_busy_r%0d", i), 32'(if_a.RSbusy_o), 32'd0);
      checkOutput($sformatf("reset_rt_busy_r%0d", 31 - i), 32'(if_a.RTbusy_o), 32'd0);
    end

    // Plain write then read on the next cycle
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r5_data", if_a.RSdata_o, 32'h12345678);
    checkOutput("r5_busy", 32'(if_a.RSbusy_o), 32'd0);

    // r0 ignores write, issue and forwarding
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0);
    checkOutput("r0_fwd_blocked", if_a.RSdata_o, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r0_data", if_a.RSdata_o, 32'h0);
    checkOutput("r0_busy", 32'(if_a.RSbusy_o), 32'd0);
    checkOutput("r0_pend", 32'(if_a.PendCnt_o), 32'd0);

    // Issue r7, then write-back with forwarding
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r7_busy", 32'(if_a.RTbusy_o), 32'd1);
    checkOutput("r7_pend", 32'(if_a.PendCnt_o), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
    checkOutput("r7_fwd_data", if_a.RTdata_o, 32'hA5A5A5A5);
    checkOutput("r7_fwd_busy", 32'(if_a.RTbusy_o), 32'd0);
    checkOutput("r7_nofwd_data", if_b.RTdata_o, 32'h0);
    checkOutput("r7_nofwd_busy", 32'(if_b.RTbusy_o), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r7_pend_after", 32'(if_a.PendCnt_o), 32'd0);
    checkOutput("r7_data_after", if_a.RTdata_o, 32'hA5A5A5A5);

    // Issue and write-back to r3 in the same cycle: busy stays set
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3);
    tick();
    applyStimulus(1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r3_data", if_a.RSdata_o, 32'h33333333);
    checkOutput("r3_busy", 32'(if_a.RSbusy_o), 32'd1);
    checkOutput("r3_pend", 32'(if_a.PendCnt_o), 32'd1);

    // Issue r1, r2, r4 and re-issue r1 (already busy)
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1);
    tick();
    applyStimulus(1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("multi_pend", 32'(if_a.PendCnt_o), 32'd4);
    checkOutput("r1_busy", 32'(if_a.RSbusy_o), 32'd1);

    // Reset dominates a simultaneous write-back and issue
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 32'h0000FFFF, 1'b1, 5'd6);
    tick();
    applyStimulus(1'b0, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("rst_pend", 32'(if_a.PendCnt_o), 32'd0);
    checkOutput("rst_r2_data", if_a.RSdata_o, 32'h0);
    checkOutput("rst_r3_data", if_a.RTdata_o, 32'h0);
    checkOutput("rst_r2_busy", 32'(if_a.RSbusy_o), 32'd0);
    checkOutput("rst_r3_busy", 32'(if_a.RTbusy_o), 32'd0);
    applyStimulus(1'b0, 5'd5, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("rst_r5_data", if_a.RSdata_o, 32'h0);
    checkOutput("rst_r7_data", if_a.RTdata_o, 32'h0);

    // Double issue of r10 is cleared by a single write-back
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
    tick();
    tick();
    applyStimulus(1'b0, 5'd10, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r10_pend", 32'(if_a.PendCnt_o), 32'd1);
    applyStimulus(1'b0, 5'd10, 5'd0, 1'b1, 5'd10, 32'h0000CAFE, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd10, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r10_pend_clr", 32'(if_a.PendCnt_o), 32'd0);
    checkOutput("r10_busy_clr", 32'(if_a.RSbusy_o), 32'd0);

    // Write-back to a non-busy entry writes data, busy stays clear
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd11, 32'h0BADF00D, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd11, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r11_data", if_a.RSdata_o, 32'h0BADF00D);
    checkOutput("r11_busy", 32'(if_a.RSbusy_o), 32'd0);
    checkOutput("r11_pend", 32'(if_a.PendCnt_o), 32'd0);

    // Non-forwarding build shows the old value until the edge
    applyStimulus(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h00000001, 1'b0, 5'd0);
    checkOutput("r9_nofwd_old", if_b.RSdata_o, 32'h0);
    checkOutput("r9_fwd_new", if_a.RSdata_o, 32'h00000001);
    tick();
    applyStimulus(1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r9_nofwd_next", if_b.RSdata_o, 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/registers_scoreboard.md
REGISTERS_SCOREBOARD -- requirements
Module: registers_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes and issues.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port RSaddr_i, input, ADDR_W: read port S address.
REQ-008 SHALL have port RTaddr_i, input, ADDR_W: read port T address.
REQ-009 SHALL have port RDaddr_i, input, ADDR_W: write-back address.
REQ-010 SHALL have port RDdata_i, input, DATA_W: write-back data.
REQ-011 SHALL have port RegWrite_i, input, 1: write-back enable.
REQ-012 SHALL have port Issue_i, input, 1: a producer of IssueAddr_i enters the pipeline.
REQ-013 SHALL have port IssueAddr_i, input, ADDR_W: destination register of the issued producer.
REQ-014 SHALL have port RSdata_o, output, DATA_W: read data S, combinational.
REQ-015 SHALL have port RTdata_o, output, DATA_W: read data T, combinational.
REQ-016 SHALL have port RSbusy_o, output, 1: RSdata_o is not yet valid; consumer must stall.
REQ-017 SHALL have port RTbusy_o, output, 1: RTdata_o is not yet valid.
REQ-018 SHALL have port PendCnt_o, output, ADDR_W+1: registered count of busy registers.

Function
REQ-019 Write: at rising edge with RegWrite_i=1, entry RDaddr_i SHALL take RDdata_i, except address 0 when ZERO_REG=1.
REQ-020 Read: RSdata_o SHALL equal the entry at RSaddr_i with zero latency; likewise RTdata_o.
REQ-021 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of write or bypass.
REQ-022 With BYPASS=1, RegWrite_i=1 and RDaddr_i equal to the read address (non-zero or ZERO_REG=0), the port SHALL output RDdata_i the same cycle; with BYPASS=0 it SHALL output the old value.
REQ-023 Scoreboard: one busy bit per entry; at rising edge, Issue_i=1 SHALL set busy[IssueAddr_i] and RegWrite_i=1 SHALL clear busy[RDaddr_i].
REQ-024 Issue and write-back to the same address in one cycle: set SHALL win (busy remains 1).
REQ-025 Issue to an already-busy entry SHALL be accepted without error; the first subsequent write-back clears it.
REQ-026 Write-back to a non-busy entry SHALL write data and leave busy at 0.
REQ-027 Issue to address 0 with ZERO_REG=1 SHALL be ignored; busy[0] SHALL stay 0.
REQ-028 RSbusy_o SHALL be busy[RSaddr_i], forced 0 when BYPASS=1 and a write-back to RSaddr_i occurs that cycle; likewise RTbusy_o.
REQ-029 PendCnt_o SHALL equal the number of set busy bits after each edge, range 0..2**ADDR_W.

Reset
REQ-030 With rst_i=1 at a rising edge, all entries SHALL become 0, all busy bits 0 and PendCnt_o 0.
REQ-031 Reset SHALL dominate any simultaneous write or issue, including mid-operation with busy entries.
REQ-032 After reset, RSdata_o/RTdata_o SHALL read 0 and RSbusy_o/RTbusy_o SHALL read 0 for every address.

Structure
REQ-033 Package registers_pkg SHALL hold DATA_W/ADDR_W defaults and derived depth constant.
REQ-034 Busy-bit array, set/clear priority and PendCnt_o SHALL live in sub-module reg_scoreboard; storage and bypass muxing stay in the top.

Verification
REQ-035 Reset, then write 0x12345678 to r5, read r5 next cycle -> RSdata_o=0x12345678, RSbusy_o=0.
REQ-036 Write 0xDEADBEEF to r0 and issue r0 (ZERO_REG=1) -> r0 reads 0, RSbusy_o=0, PendCnt_o=0.
REQ-037 Issue r7; next cycle RTaddr_i=7 -> RTbusy_o=1, PendCnt_o=1; write-back 0xA5A5A5A5 to r7 with RTaddr_i=7 -> same cycle RTdata_o=0xA5A5A5A5, RTbusy_o=0 (BYPASS=1); next cycle PendCnt_o=0.
REQ-038 Same cycle Issue r3 and write-back r3 -> r3 data updated, busy[3]=1, PendCnt_o=1.
REQ-039 Issue r1,r2,r4 then assert rst_i with RegWrite_i=1 to r2 -> all data 0, PendCnt_o=0.
REQ-040 BYPASS=0 build: write 0x1 to r9 while reading r9 -> old value that cycle, 0x1 next cycle.
